// File: rtl/lru_access_sequencer.sv
// Multi-cycle scan/update/done sequencer over a small fully-associative LRU key/value table.
// Optional hit/miss statistics counters are built only when LRU_SEQ_STATS_EN is defined.
module lru_access_sequencer #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned KEY_W   = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        state_i,
  input  logic              set_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o,
  output logic              evict_o,
  output logic [KEY_W-1:0]  evict_key_o,
  output logic [7:0]        hit_cnt_o,
  output logic [7:0]        miss_cnt_o
);

  localparam int unsigned AW = $clog2(ENTRIES);
  localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, UPDATE, DONE} state_t;
  state_t state, state_next;

  logic              valid_mem [ENTRIES];
  logic [KEY_W-1:0]  key_mem   [ENTRIES];
  logic [DATA_W-1:0] data_mem  [ENTRIES];
  logic [AW-1:0]     age_mem   [ENTRIES];

  logic              set_prev;
  logic              op_wr;
  logic [KEY_W-1:0]  req_key;
  logic [DATA_W-1:0] req_data;
  logic [AW-1:0]     idx;
  logic              hit_found, inv_found;
  logic [AW-1:0]     hit_idx, inv_idx, lru_idx;

  logic              hit_r, evict_r;
  logic [DATA_W-1:0] data_r;
  logic [KEY_W-1:0]  evict_key_r;

  logic              mode_ok, capture;
  logic [AW-1:0]     victim, target;
  logic              touch, evict_now;

  assign mode_ok = (state_i == 3'b010) || (state_i == 3'b001);
  assign capture = (state == IDLE) && set_i && !set_prev && mode_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = SCAN;
      SCAN:    if (idx == LAST) state_next = UPDATE;
      UPDATE:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
    done_o = (state == DONE);
  end

  always_comb begin
    victim    = inv_found ? inv_idx : lru_idx;
    target    = hit_found ? hit_idx : victim;
    touch     = hit_found || op_wr;
    evict_now = op_wr && !hit_found && valid_mem[victim];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      set_prev    <= 1'b0;
      op_wr       <= 1'b0;
      req_key     <= '0;
      req_data    <= '0;
      idx         <= '0;
      hit_found   <= 1'b0;
      inv_found   <= 1'b0;
      hit_idx     <= '0;
      inv_idx     <= '0;
      lru_idx     <= '0;
      hit_r       <= 1'b0;
      data_r      <= '0;
      evict_r     <= 1'b0;
      evict_key_r <= '0;
      for (int unsigned j = 0; j < ENTRIES; j++) begin
        valid_mem[j] <= 1'b0;
        key_mem[j]   <= '0;
        data_mem[j]  <= '0;
        age_mem[j]   <= AW'(j);
      end
    end else begin
      set_prev <= set_i;
      case (state)
        IDLE: if (capture) begin
          op_wr     <= (state_i == 3'b010);
          req_key   <= key_i;
          req_data  <= data_i;
          idx       <= '0;
          hit_found <= 1'b0;
          inv_found <= 1'b0;
        end
        SCAN: begin
          if (valid_mem[idx] && key_mem[idx] == req_key && !hit_found) begin
            hit_found <= 1'b1;
            hit_idx   <= idx;
          end
          if (!valid_mem[idx] && !inv_found) begin
            inv_found <= 1'b1;
            inv_idx   <= idx;
          end
          if (age_mem[idx] == LAST) lru_idx <= idx;
          idx <= idx + AW'(1);
        end
        UPDATE: begin
          // Write hit rewrites the same key, so one write path serves hit and allocate.
          if (op_wr) begin
            valid_mem[target] <= 1'b1;
            key_mem[target]   <= req_key;
            data_mem[target]  <= req_data;
          end
          if (touch) begin
            for (int unsigned j = 0; j < ENTRIES; j++) begin
              if (AW'(j) == target)
                age_mem[j] <= '0;
              else if (age_mem[j] < age_mem[target])
                age_mem[j] <= age_mem[j] + AW'(1);
            end
          end
          hit_r       <= hit_found;
          data_r      <= (!op_wr && hit_found) ? data_mem[hit_idx] : '0;
          evict_r     <= evict_now;
          evict_key_r <= evict_now ? key_mem[victim] : '0;
        end
        default: ;
      endcase
    end
  end

  assign hit_o       = hit_r;
  assign data_o      = data_r;
  assign evict_o     = evict_r;
  assign evict_key_o = evict_key_r;

`ifdef LRU_SEQ_STATS_EN
  logic [7:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == UPDATE) begin
      if (hit_found) begin
        if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
      end else begin
        if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_lru_access_sequencer.sv
// Directed bench for lru_access_sequencer: recency-list model plus literal scenario checks.
// Honours LRU_SEQ_STATS_EN for the statistics expectations.
module tb_lru_access_sequencer;

  localparam int unsigned E  = 4;
  localparam int unsigned KW = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_i, set_i;
  logic [2:0]    state_i;
  logic [KW-1:0] key_i;
  logic [DW-1:0] data_i;
  logic          busy_o, done_o, hit_o, evict_o;
  logic [DW-1:0] data_o;
  logic [KW-1:0] evict_key_o;
  logic [7:0]    hit_cnt_o, miss_cnt_o;

  lru_access_sequencer #(.ENTRIES(E), .KEY_W(KW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .state_i(state_i), .set_i(set_i),
    .key_i(key_i), .data_i(data_i), .busy_o(busy_o), .done_o(done_o),
    .hit_o(hit_o), .data_o(data_o), .evict_o(evict_o), .evict_key_o(evict_key_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: keys/data ordered most-recently-used first.
  logic [KW-1:0] mk[$], sk[$];
  logic [DW-1:0] md[$], sd[$];
  bit            active = 0;
  int            cap = 0;
  logic          p_hit, p_ev;
  logic [DW-1:0] p_data;
  logic [KW-1:0] p_evk;
  logic          e_hit = 0, e_ev = 0;
  logic [DW-1:0] e_data = '0;
  logic [KW-1:0] e_evk = '0;
  int            e_hits = 0, e_miss = 0;
  int            done_seen = 0, last_done_cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit eb, ed;
    eb = active && cyc >= cap && cyc <= cap + E + 1;
    ed = active && cyc == cap + E + 1;
    if (ed) begin
      e_hit = p_hit; e_data = p_data; e_ev = p_ev; e_evk = p_evk;
      mk = sk; md = sd;
      if (p_hit) begin if (e_hits < 255) e_hits++; end
      else begin if (e_miss < 255) e_miss++; end
      active = 0;
    end
    if (done_o === 1'b1) begin done_seen++; last_done_cyc = cyc; end
    chk("busy", busy_o, eb);
    chk("done", done_o, ed);
    chk("hit", hit_o, e_hit);
    chk("data", data_o, e_data);
    chk("evict", evict_o, e_ev);
    chk("evict_key", evict_key_o, e_evk);
    if (!eb) begin
`ifdef LRU_SEQ_STATS_EN
      chk("hit_cnt", hit_cnt_o, e_hits);
      chk("miss_cnt", miss_cnt_o, e_miss);
`else
      chk("hit_cnt", hit_cnt_o, 0);
      chk("miss_cnt", miss_cnt_o, 0);
`endif
    end
  end

  task automatic do_reset();
    rst_i = 1; set_i = 0; state_i = 3'b000;
    @(posedge clk); #1;
    rst_i = 0;
    active = 0; mk.delete(); md.delete();
    e_hit = 0; e_data = '0; e_ev = 0; e_evk = '0; e_hits = 0; e_miss = 0;
  endtask

  // Issues a request; returns at the first SCAN cycle (cyc == cap).
  task automatic op(input bit wr, input logic [KW-1:0] k, input logic [DW-1:0] d, input bit hold);
    int p;
    logic [DW-1:0] dd;
    p = -1;
    sk = mk; sd = md;
    for (int i = 0; i < sk.size(); i++) if (sk[i] == k) p = i;
    p_ev = 0; p_evk = '0; p_data = '0;
    if (p >= 0) begin
      p_hit = 1;
      if (!wr) p_data = sd[p];
      dd = wr ? d : sd[p];
      sk.delete(p); sd.delete(p);
      sk.push_front(k); sd.push_front(dd);
    end else begin
      p_hit = 0;
      if (wr) begin
        if (sk.size() == E) begin
          p_ev = 1; p_evk = sk[sk.size()-1];
          void'(sk.pop_back()); void'(sd.pop_back());
        end
        sk.push_front(k); sd.push_front(d);
      end
    end
    state_i = wr ? 3'b010 : 3'b001; key_i = k; data_i = d; set_i = 1;
    cap = cyc + 1; active = 1;
    @(posedge clk); #1;
    key_i = ~k; data_i = ~d;
    if (!hold) begin set_i = 0; state_i = 3'b100; end
  endtask

  task automatic run(input bit wr, input logic [KW-1:0] k, input logic [DW-1:0] d);
    op(wr, k, d, 0);
    repeat (E + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    int raise, d0;
    rst_i = 1; set_i = 0; state_i = 3'b000; key_i = '0; data_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    chk("reset_busy", busy_o, 0);
    chk("reset_hit", hit_o, 0);

    // RD after reset: miss, fixed latency
    run(0, 4'd3, 8'h00);
    chk("rd_miss_hit", hit_o, 0);
    chk("rd_miss_data", data_o, 0);
    chk("rd_miss_evict", evict_o, 0);
    chk("latency", last_done_cyc - (cap - 1), 6);

    // WR then RD hit, then overwrite
    do_reset();
    run(1, 4'd3, 8'hA5);
    run(0, 4'd3, 8'h00);
    chk("rd_hit", hit_o, 1);
    chk("rd_hit_data", data_o, 8'hA5);
`ifdef LRU_SEQ_STATS_EN
    chk("stat_hit1", hit_cnt_o, 1);
    chk("stat_miss1", miss_cnt_o, 1);
`endif
    run(1, 4'd3, 8'h5A);
    chk("wr_hit", hit_o, 1);
    chk("wr_hit_data", data_o, 0);
    run(0, 4'd3, 8'h00);
    chk("overwrite_data", data_o, 8'h5A);

    // Fill then evict LRU
    do_reset();
    for (int i = 1; i <= 4; i++) run(1, KW'(i), DW'(i * 8'h11));
    chk("fill_no_evict", evict_o, 0);
    run(1, 4'd5, 8'h55);
    chk("evict", evict_o, 1);
    chk("evict_key1", evict_key_o, 1);
    run(0, 4'd1, 8'h00);
    chk("evicted_miss", hit_o, 0);
    run(0, 4'd5, 8'h00);
    chk("new_hit", hit_o, 1);
    chk("new_data", data_o, 8'h55);

    // Read refreshes key 1, so key 2 becomes LRU
    do_reset();
    for (int i = 1; i <= 4; i++) run(1, KW'(i), DW'(i * 8'h11));
    run(0, 4'd1, 8'h00);
    chk("refresh_data", data_o, 8'h11);
    run(1, 4'd5, 8'h5A);
    chk("evict_key2", evict_key_o, 2);

    // Held set_i with mode change mid-SCAN
    do_reset();
    d0 = done_seen;
    raise = cyc;
    op(1, 4'd9, 8'h3C, 1);
    @(posedge clk); #1;
    state_i = 3'b100;
    repeat (E + 1) @(posedge clk);
    #1;
    state_i = 3'b010;
    while (cyc < raise + 20) begin @(posedge clk); #1; end
    set_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_one_done", done_seen - d0, 1);
    chk("hold_idle", busy_o, 0);
    run(0, 4'd9, 8'h00);
    chk("hold_write_data", data_o, 8'h3C);

    // Reset during SCAN aborts
    do_reset();
    run(1, 4'd7, 8'h77);
    d0 = done_seen;
    op(0, 4'd7, 8'h00, 0);
    @(posedge clk); #1;
    do_reset();
    repeat (E + 3) @(posedge clk);
    #1;
    chk("abort_no_done", done_seen - d0, 0);
    run(0, 4'd7, 8'h00);
    chk("abort_rd_miss", hit_o, 0);

`ifdef LRU_SEQ_STATS_EN
    do_reset();
    for (int i = 0; i < 258; i++) run(0, 4'd2, 8'h00);
    chk("miss_saturate", miss_cnt_o, 255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
